mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Time-shares one pipelined signed multiplier among NUM_REQ requesters, for example operator envelope and feedback paths that each need an occasional product.
- Round-robin grant; at most one operand pair issued per cycle.
- A tag pipeline matched to the multiplier latency routes each product back to the requester that issued it.
- Sits between the operator datapath clients and a single DSP-mapped multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTHA, 16, width of signed operand a.
- DATA_WIDTHB, 16, width of signed operand b.
- MULT_DELAY, 2, multiplier input-to-output latency in cycles (≥2, DSP minimum).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when 0, no new grants; in-flight products still drain.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_a  in  NUM_REQ x DATA_WIDTHA  signed operand a per requester.
- req_b  in  NUM_REQ x DATA_WIDTHB  signed operand b per requester.
- req_ready  out  NUM_REQ  one-hot grant; handshake = req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse marking the product owner.
- rsp_result  out  DATA_WIDTHA+DATA_WIDTHB  signed product, shared by all requesters.
- rsp_id  out  clog2(NUM_REQ)  index of the owning requester.
- in_flight  out  clog2(MULT_DELAY+2)  number of products issued but not yet returned.

Behaviour:
- Reset (synchronous, active-high): rsp_valid=0, rsp_result=0, rsp_id=0, in_flight=0, rr pointer=0, tag pipeline cleared.
- req_ready combinational:
  - Computed from req_valid, the rr pointer and enable.
  - At most one bit set.
  - Never set for a requester whose req_valid is 0.
  - All zero while reset=1 or enable=0.
- Round robin:
  - Search starts at the pointer index and wraps at NUM_REQ-1 -> 0.
  - After a handshake on index g, pointer <= (g+1) mod NUM_REQ.
  - With no handshake, the pointer holds.
- Issue path:
  - The granted requester's req_a/req_b are muxed straight into the multiplier.
  - When nothing is granted, the mux drives 0.
- Latency and response timing:
  - Handshake in cycle t -> rsp_valid[g]=1, rsp_id=g, rsp_result=a*b (full precision, signed) in cycle t+MULT_DELAY+1, exactly one cycle.
  - Response outputs are registered.
- Throughput: one issue per cycle sustained; back-to-back grants produce back-to-back responses in issue order.
- Tag pipeline:
  - MULT_DELAY stages of {valid, id}, advancing every cycle unconditionally, like the multiplier itself.
  - No response backpressure: requesters must accept a product in its pulse cycle.
- rsp_result and rsp_id hold their last values when rsp_valid=0.
- in_flight:
  - +1 on a handshake, -1 on a response cycle; a simultaneous issue and return leaves it unchanged.
  - Maximum value is MULT_DELAY+1.
- Extremes: operand a=-2^(DATA_WIDTHA-1) with b=-2^(DATA_WIDTHB-1) yields the positive product with no overflow; the output width is sufficient.
- Reset mid-operation:
  - Tag valids are cleared, so no response is produced for products already in flight.
  - The multiplier data pipe is not reset; its data is ignored.
- enable falling mid-stream: products already in flight still complete; no new grants until enable=1.
- A requester dropping req_valid while not granted loses nothing; no state is held per requester.

Decomposition:
- Shared package (opl3 common package):
  - localparam MULT_SHARE_ID_W = clog2(NUM_REQ), or a function computing it.
  - A typedef for the tag struct {logic valid; logic [ID_W-1:0] id}.
- Sub-module rr_arbiter: combinational one-hot grant from a request vector and pointer, plus pointer update. It is reusable for the team's other shared resources.
- The multiplier is the existing mult_signed instance with OUTPUT_DELAY=MULT_DELAY.

Test Plan:
- Reset, then req_valid=4'b0001, a=3, b=-5 for 1 cycle (t=2) -> req_ready=0001 at t=2; rsp_valid=0001, rsp_id=0, rsp_result=-15 at t=5 (MULT_DELAY=2), low otherwise.
- All four requesters valid continuously, pointer=0 -> grants 0,1,2,3,0,… one per cycle; responses in the same order with correct products, 4 consecutive rsp pulses; in_flight saturates at 3.
- a=-32768, b=-32768 -> rsp_result=32'sh4000_0000; a=32767, b=-32768 -> 32'shC000_8000.
- Issue to requesters 1 and 2 in consecutive cycles, assert reset in the following cycle -> no rsp_valid ever for either issue; in_flight=0; pointer=0 after reset.
- enable=0 with all requesters valid -> req_ready=0 and pointer frozen; after enable=1 the grant goes to the held pointer index; a product issued before the enable drop still returns.
- Only requester 3 valid after a grant to 3 -> the pointer wraps to 0 and the next grant goes to 3 again (search wraps), with no idle cycle between grants.

Source files
------------

// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and helpers for the time-shared multiplier arbiter.
// The tag struct carries the owning requester id alongside each product.
package mult_share_arbiter_pkg;

    // Widest id needed for the supported range of 2..8 requesters.
    localparam int MULT_SHARE_ID_MAX_W = 3;

    function automatic int mult_share_id_w(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    typedef struct packed {
        logic                           valid;
        logic [MULT_SHARE_ID_MAX_W-1:0] id;
    } mult_share_tag_t;

    localparam mult_share_tag_t MULT_SHARE_TAG_IDLE = '{valid: 1'b0, id: '0};

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester-facing bus of the shared multiplier: operand requests and product responses.
// Handshake: an operand pair transfers in any cycle where req_valid[i] & req_ready[i]; rsp_valid is a one-cycle pulse with no backpressure.
interface mult_share_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTHA = 16,
    parameter int DATA_WIDTHB = 16,
    parameter int MULT_DELAY  = 2
);
    import mult_share_arbiter_pkg::*;

    localparam int ID_W = mult_share_id_w(NUM_REQ);
    localparam int IF_W = $clog2(MULT_DELAY + 2);

    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0][DATA_WIDTHA-1:0] req_a;
    logic [NUM_REQ-1:0][DATA_WIDTHB-1:0] req_b;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_REQ-1:0]                  rsp_valid;
    logic [DATA_WIDTHA+DATA_WIDTHB-1:0]  rsp_result;
    logic [ID_W-1:0]                     rsp_id;
    logic [IF_W-1:0]                     in_flight;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_result, rsp_id, in_flight
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_result, rsp_id, in_flight
    );

endinterface

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searching upward from ptr with wrap,
// and the pointer value to load (one past the winner, or unchanged when idle).
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] ptr_next
);

    int cand;

    always_comb begin
        gnt       = '0;
        gnt_idx   = ptr;
        gnt_valid = 1'b0;
        cand      = 0;
        if (en) begin
            for (int off = 0; off < N; off++) begin
                cand = (int'(ptr) + off) % N;
                if (!gnt_valid && req[IDX_W'(cand)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = IDX_W'(cand);
                end
            end
        end
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
        ptr_next = gnt_valid ? IDX_W'((int'(gnt_idx) + 1) % N) : ptr;
    end

endmodule

// File: rtl/mult_signed.sv
// Pipelined signed multiplier with OUTPUT_DELAY register stages; maps onto a DSP block.
// The data pipe is deliberately not reset so it packs into the DSP registers.
module mult_signed #(
    parameter int WA           = 16,
    parameter int WB           = 16,
    parameter int OUTPUT_DELAY = 2
) (
    input  logic                 clk,
    input  logic signed [WA-1:0] a,
    input  logic signed [WB-1:0] b,
    output logic signed [WA+WB-1:0] p
);

    logic signed [WA+WB-1:0] prod_d;
    logic signed [WA+WB-1:0] pipe_q [OUTPUT_DELAY];

    always_comb begin
        prod_d = (WA+WB)'(a) * (WA+WB)'(b);
    end

    always_ff @(posedge clk) begin
        pipe_q[0] <= prod_d;
        for (int i = 1; i < OUTPUT_DELAY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign p = pipe_q[OUTPUT_DELAY-1];

endmodule

// File: rtl/mult_share_arbiter.sv
// Time-shares one pipelined signed multiplier among NUM_REQ requesters with round-robin grant;
// a tag pipe matched to the multiplier latency steers each product back to its issuer.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTHA = 16,
    parameter int DATA_WIDTHB = 16,
    parameter int MULT_DELAY  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    mult_share_arbiter_if.slave  bus
);

    localparam int ID_W = mult_share_id_w(NUM_REQ);
    localparam int IF_W = $clog2(MULT_DELAY + 2);
    localparam int PW   = DATA_WIDTHA + DATA_WIDTHB;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .en        (enable & ~reset),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .ptr_next  (ptr_d)
    );

    assign bus.req_ready = gnt;

    logic signed [DATA_WIDTHA-1:0] mul_a;
    logic signed [DATA_WIDTHB-1:0] mul_b;
    logic signed [PW-1:0]          mul_p;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (gnt_valid) begin
            mul_a = bus.req_a[gnt_idx];
            mul_b = bus.req_b[gnt_idx];
        end
    end

    mult_signed #(.WA(DATA_WIDTHA), .WB(DATA_WIDTHB), .OUTPUT_DELAY(MULT_DELAY)) u_mult (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    // Tag pipe advances unconditionally in lockstep with the multiplier stages.
    mult_share_tag_t tag_q [MULT_DELAY];
    mult_share_tag_t tag_d [MULT_DELAY];
    mult_share_tag_t tag_out;

    always_comb begin
        tag_d[0].valid = gnt_valid;
        tag_d[0].id    = MULT_SHARE_ID_MAX_W'(gnt_idx);
        for (int i = 1; i < MULT_DELAY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    assign tag_out = tag_q[MULT_DELAY-1];

    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [PW-1:0]      rsp_result_q, rsp_result_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [IF_W-1:0]    in_flight_q, in_flight_d;

    always_comb begin
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        if (tag_out.valid) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid_d[i] = (tag_out.id == MULT_SHARE_ID_MAX_W'(i));
            end
            rsp_result_d = mul_p;
            rsp_id_d     = tag_out.id[ID_W-1:0];
        end
        in_flight_d = in_flight_q + IF_W'(gnt_valid) - IF_W'(|rsp_valid_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_id_q     <= '0;
            in_flight_q  <= '0;
            for (int i = 0; i < MULT_DELAY; i++) begin
                tag_q[i] <= MULT_SHARE_TAG_IDLE;
            end
        end else begin
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            in_flight_q  <= in_flight_d;
            for (int i = 0; i < MULT_DELAY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.in_flight  = in_flight_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: a table of isolated single-issue products,
// then hand-written multi-cycle sequences for streaming, reset, enable and wrap cases.
module tb_mult_share_arbiter;

    logic clk;
    logic reset;
    logic enable;

    mult_share_arbiter_if #(.NUM_REQ(4), .DATA_WIDTHA(16), .DATA_WIDTHB(16), .MULT_DELAY(2)) bus ();

    mult_share_arbiter #(.NUM_REQ(4), .DATA_WIDTHA(16), .DATA_WIDTHB(16), .MULT_DELAY(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        int                 idx;
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic [31:0]        exp_p;
    } vec_t;

    vec_t vecs [6];

    logic [31:0] exp_q [$];
    logic [1:0]  exp_id_q [$];
    logic [31:0] stream_prod [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    // Single isolated issue, then follow it through to the response pulse.
    task automatic do_one(input vec_t v);
        logic [3:0] oh;
        oh = 4'(1 << v.idx);
        bus.req_valid[v.idx] = 1'b1;
        bus.req_a[v.idx]     = v.a;
        bus.req_b[v.idx]     = v.b;
        #1;
        check("vec_ready", 32'(bus.req_ready), 32'(oh));
        next_cycle();
        idle_inputs();
        #1;
        check("vec_rsp_early1", 32'(bus.rsp_valid), 32'h0);
        check("vec_inflight1", 32'(bus.in_flight), 32'd1);
        next_cycle();
        check("vec_rsp_early2", 32'(bus.rsp_valid), 32'h0);
        next_cycle();
        check("vec_rsp_valid", 32'(bus.rsp_valid), 32'(oh));
        check("vec_rsp_id", 32'(bus.rsp_id), 32'(v.idx));
        check("vec_rsp_result", bus.rsp_result, v.exp_p);
        check("vec_inflight3", 32'(bus.in_flight), 32'd1);
        next_cycle();
        check("vec_rsp_after", 32'(bus.rsp_valid), 32'h0);
        check("vec_result_hold", bus.rsp_result, v.exp_p);
        check("vec_inflight_drained", 32'(bus.in_flight), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{idx: 0, a: 16'sd3,      b: -16'sd5,     exp_p: 32'hFFFF_FFF1};
        vecs[1] = '{idx: 1, a: -16'sd32768, b: -16'sd32768, exp_p: 32'h4000_0000};
        vecs[2] = '{idx: 2, a: 16'sd32767,  b: -16'sd32768, exp_p: 32'hC000_8000};
        vecs[3] = '{idx: 3, a: -16'sd1,     b: -16'sd1,     exp_p: 32'h0000_0001};
        vecs[4] = '{idx: 1, a: 16'sd123,    b: 16'sd45,     exp_p: 32'd5535};
        vecs[5] = '{idx: 2, a: -16'sd7,     b: 16'sd9,      exp_p: 32'hFFFF_FFC1};
        stream_prod = '{32'd10, 32'd40, 32'd90, 32'd160};

        // Reset state, with every requester asserting valid during reset.
        enable = 1'b1;
        reset  = 1'b1;
        idle_inputs();
        bus.req_valid = '1;
        next_cycle();
        next_cycle();
        check("reset_ready", 32'(bus.req_ready), 32'h0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset_rsp_result", bus.rsp_result, 32'h0);
        check("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
        check("reset_inflight", 32'(bus.in_flight), 32'h0);
        reset = 1'b0;
        idle_inputs();

        for (int k = 0; k < 6; k++) begin
            do_one(vecs[k]);
        end

        // Streaming: all four valid for 8 cycles from pointer 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i] = 16'(i + 1);
            bus.req_b[i] = 16'(10 * (i + 1));
        end
        for (int c = 0; c < 12; c++) begin
            int issued;
            int returned;
            bus.req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            check("stream_ready", 32'(bus.req_ready), (c < 8) ? 32'(1 << (c % 4)) : 32'h0);
            issued   = (c < 8) ? c : 8;
            returned = (c < 3) ? 0 : ((c - 3 > 8) ? 8 : c - 3);
            check("stream_inflight", 32'(bus.in_flight), 32'(issued - returned));
            if (c >= 3 && c < 11 && exp_q.size() > 0) begin
                check("stream_rsp_valid", 32'(bus.rsp_valid), 32'(1 << exp_id_q[0]));
                check("stream_rsp_id", 32'(bus.rsp_id), 32'(exp_id_q[0]));
                check("stream_rsp_result", bus.rsp_result, exp_q[0]);
                void'(exp_q.pop_front());
                void'(exp_id_q.pop_front());
            end else begin
                check("stream_rsp_idle", 32'(bus.rsp_valid), 32'h0);
            end
            if (c < 8) begin
                exp_q.push_back(stream_prod[c % 4]);
                exp_id_q.push_back(2'(c % 4));
            end
            next_cycle();
        end
        check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while two products are in flight: neither may ever respond.
        do_reset();
        bus.req_valid = 4'b0110;
        bus.req_a[1] = 16'sd7;  bus.req_b[1] = 16'sd8;
        bus.req_a[2] = 16'sd9;  bus.req_b[2] = 16'sd10;
        #1;
        check("rst_mid_ready_c0", 32'(bus.req_ready), 32'b0010);
        next_cycle();
        check("rst_mid_ready_c1", 32'(bus.req_ready), 32'b0100);
        next_cycle();
        bus.req_valid = 4'b0000;
        reset = 1'b1;
        #1;
        check("rst_mid_ready_in_reset", 32'(bus.req_ready), 32'h0);
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'h0);
            check("rst_mid_inflight", 32'(bus.in_flight), 32'h0);
            next_cycle();
        end
        bus.req_valid = 4'hF;
        #1;
        check("rst_mid_ptr_zero", 32'(bus.req_ready), 32'b0001);
        next_cycle();
        idle_inputs();
        repeat (4) next_cycle();

        // Enable drop: in-flight product completes, pointer frozen, grant resumes at held index.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i] = 16'(i + 1);
            bus.req_b[i] = 16'(10 * (i + 1));
        end
        bus.req_valid = 4'hF;
        #1;
        check("en_ready_c0", 32'(bus.req_ready), 32'b0001);
        next_cycle();
        enable = 1'b0;
        #1;
        check("en_ready_off_c1", 32'(bus.req_ready), 32'h0);
        check("en_inflight_c1", 32'(bus.in_flight), 32'd1);
        next_cycle();
        check("en_ready_off_c2", 32'(bus.req_ready), 32'h0);
        next_cycle();
        check("en_ready_off_c3", 32'(bus.req_ready), 32'h0);
        check("en_rsp_valid_c3", 32'(bus.rsp_valid), 32'b0001);
        check("en_rsp_result_c3", bus.rsp_result, 32'd10);
        check("en_inflight_c3", 32'(bus.in_flight), 32'd1);
        next_cycle();
        enable = 1'b1;
        #1;
        check("en_ready_resume", 32'(bus.req_ready), 32'b0010);
        check("en_rsp_idle_c4", 32'(bus.rsp_valid), 32'h0);
        check("en_inflight_c4", 32'(bus.in_flight), 32'd0);
        next_cycle();
        idle_inputs();
        repeat (4) next_cycle();

        // Lone requester 3: pointer wraps to 0 and the search wraps back to 3 each cycle.
        do_reset();
        bus.req_valid = 4'b1000;
        bus.req_a[3] = 16'sd5;
        bus.req_b[3] = -16'sd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("wrap_ready", 32'(bus.req_ready), 32'b1000);
            next_cycle();
        end
        bus.req_valid = 4'b0000;
        for (int c = 3; c < 6; c++) begin
            #1;
            check("wrap_rsp_valid", 32'(bus.rsp_valid), 32'b1000);
            check("wrap_rsp_id", 32'(bus.rsp_id), 32'd3);
            check("wrap_rsp_result", bus.rsp_result, 32'hFFFF_FFF1);
            check("wrap_inflight", 32'(bus.in_flight), 32'(6 - c));
            next_cycle();
        end
        bus.req_valid = 4'hF;
        #1;
        check("wrap_rsp_idle", 32'(bus.rsp_valid), 32'h0);
        check("wrap_inflight_zero", 32'(bus.in_flight), 32'd0);
        check("wrap_ptr_zero", 32'(bus.req_ready), 32'b0001);
        next_cycle();
        idle_inputs();
        repeat (4) next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
